// File: rtl/gshare_predictor_pkg.sv
// Shared branch-predictor definitions: default table geometry, the predictor
// sequencer states, and the weakly-not-taken counter reset value.
package gshare_predictor_pkg;

  localparam int unsigned BPU_TABLE_ENTRIES = 64;
  localparam int unsigned BPU_CTR_WIDTH     = 2;
  localparam int unsigned BPU_GHR_WIDTH     = 6;

  // Encoding of the original fixed 2-bit bimodal table.
  typedef enum logic [1:0] {
    BhtSnt,
    BhtWnt,
    BhtWt,
    BhtSt
  } bht_state_t;

  typedef enum logic {
    INIT,
    RUN
  } bpu_state_t;

  // Largest value whose MSB is still clear: predicts not-taken, one step from taken.
  function automatic int unsigned ctr_wnt(int unsigned width);
    return (32'd1 << (width - 32'd1)) - 32'd1;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Next-state logic for an unsigned saturating up/down counter.
module sat_counter #(
  parameter int unsigned CTR_WIDTH = 2
) (
  input  logic [CTR_WIDTH-1:0] ctr,
  input  logic                 taken,
  output logic [CTR_WIDTH-1:0] ctr_next
);

  always_comb begin
    ctr_next = ctr;
    if (taken) begin
      if (ctr != '1) ctr_next = ctr + CTR_WIDTH'(1);
    end else begin
      if (ctr != '0) ctr_next = ctr - CTR_WIDTH'(1);
    end
  end

endmodule

// File: rtl/gshare_predictor.sv
// Branch direction predictor with a swept counter table. Defining BPU_GSHARE_EN
// enables the global history register and XOR indexing; otherwise bimodal.
module gshare_predictor
  import gshare_predictor_pkg::*;
#(
  parameter int unsigned TABLE_ENTRIES = BPU_TABLE_ENTRIES,
  parameter int unsigned CTR_WIDTH     = BPU_CTR_WIDTH,
  parameter int unsigned GHR_WIDTH     = BPU_GHR_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [31:0]          pc_f,
  input  logic                 pred_valid,
  output logic                 bht_taken,
  output logic [GHR_WIDTH-1:0] pred_ghr,
  input  logic [31:0]          pc_e,
  input  logic                 cflow_valid,
  input  logic                 cflow_taken,
  input  logic [GHR_WIDTH-1:0] cflow_ghr,
  input  logic                 mispredict,
  output logic                 init_done
);

  localparam int unsigned INDEX_WIDTH = $clog2(TABLE_ENTRIES);
  localparam logic [CTR_WIDTH-1:0]   CtrWnt  = CTR_WIDTH'(ctr_wnt(CTR_WIDTH));
  localparam logic [INDEX_WIDTH-1:0] LastIdx = INDEX_WIDTH'(TABLE_ENTRIES - 1);

  bpu_state_t             state_q, state_d;
  logic [INDEX_WIDTH-1:0] ptr_q, ptr_d;

  // No reset on the array so it can map to distributed RAM; the sweep initialises it.
  logic [CTR_WIDTH-1:0]   ctr_mem [TABLE_ENTRIES];

  logic [INDEX_WIDTH-1:0] idx_f, idx_e, wr_idx;
  logic [CTR_WIDTH-1:0]   ctr_upd, wr_data;
  logic                   wr_en;

  logic unused_pc;
  assign unused_pc = ^{pc_f[31:2+INDEX_WIDTH], pc_f[1:0], pc_e[31:2+INDEX_WIDTH], pc_e[1:0]};

`ifdef BPU_GSHARE_EN
  logic [GHR_WIDTH-1:0] ghr_q, ghr_d;

  function automatic logic [GHR_WIDTH-1:0] ghr_shift(logic [GHR_WIDTH-1:0] hist, logic dir);
    logic [GHR_WIDTH:0] wide;
    wide = {hist, dir};
    return wide[GHR_WIDTH-1:0];
  endfunction

  assign idx_f = pc_f[2 +: INDEX_WIDTH] ^ INDEX_WIDTH'(ghr_q);
  assign idx_e = pc_e[2 +: INDEX_WIDTH] ^ INDEX_WIDTH'(cflow_ghr);

  // Mispredict repair wins over the speculative shift in the same cycle.
  always_comb begin
    ghr_d = ghr_q;
    if (state_q == RUN) begin
      if (mispredict) begin
        ghr_d = ghr_shift(cflow_ghr, cflow_taken);
      end else if (pred_valid) begin
        ghr_d = ghr_shift(ghr_q, bht_taken);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ghr_q <= '0;
    end else begin
      ghr_q <= ghr_d;
    end
  end
`else
  logic unused_gshare;
  assign unused_gshare = ^{cflow_ghr, mispredict, pred_valid};

  assign idx_f = pc_f[2 +: INDEX_WIDTH];
  assign idx_e = pc_e[2 +: INDEX_WIDTH];
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= INIT;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    unique case (state_q)
      INIT: begin
        ptr_d = ptr_q + INDEX_WIDTH'(1);
        if (ptr_q == LastIdx) state_d = RUN;
      end
      RUN:     state_d = RUN;
      default: state_d = INIT;
    endcase
  end

  always_comb begin
    init_done = 1'b0;
    bht_taken = 1'b0;
    pred_ghr  = '0;
    wr_en     = 1'b1;
    wr_idx    = ptr_q;
    wr_data   = CtrWnt;
    unique case (state_q)
      INIT: ;
      RUN: begin
        init_done = 1'b1;
        bht_taken = ctr_mem[idx_f][CTR_WIDTH-1];
`ifdef BPU_GSHARE_EN
        pred_ghr  = ghr_q;
`endif
        wr_en     = cflow_valid;
        wr_idx    = idx_e;
        wr_data   = ctr_upd;
      end
      default: ;
    endcase
  end

  sat_counter #(
    .CTR_WIDTH (CTR_WIDTH)
  ) u_upd_ctr (
    .ctr      (ctr_mem[idx_e]),
    .taken    (cflow_taken),
    .ctr_next (ctr_upd)
  );

  // Same-cycle reads of the entry being written see the old value.
  always_ff @(posedge clk) begin
    if (wr_en) ctr_mem[wr_idx] <= wr_data;
  end

endmodule

// File: tb/tb_gshare_predictor.sv
// Self-checking bench for gshare_predictor: behavioural table/history model,
// per-cycle output comparison, and directed literal checks.
module tb_gshare_predictor;

  localparam int unsigned E     = 64;
  localparam int unsigned CW    = 2;
  localparam int unsigned GW    = 6;
  localparam int unsigned GMASK = (1 << GW) - 1;
  localparam int unsigned CMAX  = (1 << CW) - 1;
  localparam int unsigned WNT   = (1 << (CW - 1)) - 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic [31:0]   pc_f = '0;
  logic          pred_valid = 1'b0;
  logic          bht_taken;
  logic [GW-1:0] pred_ghr;
  logic [31:0]   pc_e = '0;
  logic          cflow_valid = 1'b0;
  logic          cflow_taken = 1'b0;
  logic [GW-1:0] cflow_ghr = '0;
  logic          mispredict = 1'b0;
  logic          init_done;

  gshare_predictor #(
    .TABLE_ENTRIES (E),
    .CTR_WIDTH     (CW),
    .GHR_WIDTH     (GW)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .pc_f        (pc_f),
    .pred_valid  (pred_valid),
    .bht_taken   (bht_taken),
    .pred_ghr    (pred_ghr),
    .pc_e        (pc_e),
    .cflow_valid (cflow_valid),
    .cflow_taken (cflow_taken),
    .cflow_ghr   (cflow_ghr),
    .mispredict  (mispredict),
    .init_done   (init_done)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Model: counters as plain integers, history as an integer, sweep as a count.
  int unsigned m_ctr [E];
  int unsigned m_ghr   = 0;
  int unsigned m_swept = 0;
  bit          m_done  = 1'b0;
  bit          chk_en  = 1'b0;

  function automatic int unsigned f_idx(logic [31:0] pc, int unsigned g);
`ifdef BPU_GSHARE_EN
    return ((pc >> 2) % E) ^ g;
`else
    return (pc >> 2) % E;
`endif
  endfunction

  function automatic int unsigned m_taken();
    if (!m_done) return 0;
    return (m_ctr[f_idx(pc_f, m_ghr)] > WNT) ? 1 : 0;
  endfunction

  function automatic int unsigned m_pred_ghr();
    return m_done ? m_ghr : 0;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    int unsigned p, i, c;
    if (!m_done) begin
      m_ctr[m_swept] = WNT;
      m_swept++;
      if (m_swept == E) m_done = 1'b1;
    end else begin
      p = m_taken();
      if (cflow_valid) begin
        i = f_idx(pc_e, cflow_ghr);
        c = m_ctr[i];
        if (cflow_taken) m_ctr[i] = (c == CMAX) ? c : c + 1;
        else             m_ctr[i] = (c == 0) ? c : c - 1;
      end
`ifdef BPU_GSHARE_EN
      if (mispredict)      m_ghr = ((cflow_ghr << 1) | cflow_taken) & GMASK;
      else if (pred_valid) m_ghr = ((m_ghr << 1) | p) & GMASK;
`endif
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    if (rst_n) model_step();
    #1;
  endtask

  task automatic do_reset();
    rst_n   = 1'b0;
    m_swept = 0;
    m_done  = 1'b0;
    m_ghr   = 0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic quiet();
    pred_valid  = 1'b0;
    cflow_valid = 1'b0;
    mispredict  = 1'b0;
    cflow_taken = 1'b0;
    cflow_ghr   = '0;
  endtask

  // Runs the sweep with noisy control inputs; returns cycles until init_done.
  task automatic run_init(output int n);
    n = 0;
    while (!init_done && n < 200) begin
      pred_valid  = 1'($urandom);
      cflow_valid = 1'($urandom);
      mispredict  = 1'($urandom);
      cflow_taken = 1'($urandom);
      cflow_ghr   = GW'($urandom);
      pc_e        = $urandom;
      pc_f        = $urandom;
      cycle();
      n++;
    end
    quiet();
  endtask

  task automatic check_table_wnt(input string name);
    int bad;
    bad = 0;
    for (int i = 0; i < E; i++) if (int'(dut.ctr_mem[i]) != WNT) bad++;
    check(name, bad, 0);
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("bht_taken", int'(bht_taken), int'(m_taken()));
      check("pred_ghr", int'(pred_ghr), int'(m_pred_ghr()));
      check("init_done", int'(init_done), int'(m_done));
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    int exp_ctr [7];
    int exp_tk  [7];
    exp_ctr = '{2, 3, 3, 2, 1, 0, 0};
    exp_tk  = '{1, 1, 1, 1, 0, 0, 0};

    #1;
    chk_en = 1'b1;
    do_reset();
    check("rst_init_done", int'(init_done), 0);
    check("rst_pred_ghr", int'(pred_ghr), 0);
    check("rst_bht_taken", int'(bht_taken), 0);

    run_init(n);
    check("init_cycles", n, 64);
    for (int i = 0; i < E; i++) check("init_entry", int'(dut.ctr_mem[i]), 1);
    check("ghr_after_init", int'(pred_ghr), 0);

    // Counter walk on entry 0 with empty history.
    pc_f = 32'h100;
    pc_e = 32'h100;
    for (int k = 0; k < 7; k++) begin
      cflow_valid = 1'b1;
      cflow_taken = (k < 3);
      cycle();
      cflow_valid = 1'b0;
      check("walk_ctr", int'(dut.ctr_mem[0]), exp_ctr[k]);
      check("walk_taken", int'(bht_taken), exp_tk[k]);
    end
    quiet();

`ifdef BPU_GSHARE_EN
    do_reset();
    run_init(n);
    mispredict  = 1'b1;
    cflow_ghr   = 6'd1;
    cflow_taken = 1'b1;
    cycle();
    quiet();
    check("ghr_set3", int'(pred_ghr), 3);
    pc_f = 32'h40;
    check("xor_pred_nt", int'(bht_taken), 0);
    pc_e        = 32'h40;
    cflow_ghr   = 6'd3;
    cflow_valid = 1'b1;
    cflow_taken = 1'b1;
    cycle();
    quiet();
    check("xor_entry13", int'(dut.ctr_mem[6'h13]), 2);
    check("xor_entry10", int'(dut.ctr_mem[6'h10]), 1);
    check("xor_pred_t", int'(bht_taken), 1);
    mispredict = 1'b1;
    cflow_ghr  = 6'b010101;
    cycle();
    quiet();
    check("ghr_2a", int'(pred_ghr), 6'b101010);
    pred_valid  = 1'b1;
    mispredict  = 1'b1;
    cflow_ghr   = 6'b000111;
    cflow_taken = 1'b0;
    cycle();
    quiet();
    check("ghr_repair", int'(pred_ghr), 6'b001110);
`endif

    // Reset part-way through the sweep restarts it from entry 0.
    do_reset();
    repeat (20) cycle();
    check("midsweep_done", int'(init_done), 0);
    do_reset();
    run_init(n);
    check("restart_cycles", n, 64);
    check_table_wnt("restart_table");
    check("restart_ghr", int'(pred_ghr), 0);

    for (int k = 0; k < 3000; k++) begin
      pc_f        = {$urandom} & 32'hffff_fffc;
      pc_e        = ($urandom_range(0, 3) == 0) ? pc_f : $urandom;
      pred_valid  = 1'($urandom);
      cflow_valid = 1'($urandom);
      cflow_taken = 1'($urandom);
      cflow_ghr   = ($urandom_range(0, 1) == 0) ? pred_ghr : GW'($urandom);
      mispredict  = ($urandom_range(0, 7) == 0);
      cycle();
    end
    quiet();
    cycle();

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/gshare_predictor.md
Name: gshare_predictor

Overview:
- Parametrised successor to the 2-bit bimodal branch history table: N-bit saturating counters, configurable table depth, and a global history register (GHR) XOR-folded into the index (gshare).
- Predicts in IF using a speculative GHR. Updates in EX and repairs the GHR on mispredict.
- Owns an init sequencer that sweeps the counter RAM after reset, so the RAM stays distributed (no async reset on the array).

Parameters:
- TABLE_ENTRIES, 64, number of counters; power of 2, ≥4. INDEX_WIDTH = $clog2(TABLE_ENTRIES).
- CTR_WIDTH, 2, counter width in bits; 1..4.
- GHR_WIDTH, 6, global history bits; 1..INDEX_WIDTH.

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- pc_f  in  32  IF PC
- pred_valid  in  1  IF is consuming a prediction for a conditional branch; advances the speculative GHR
- bht_taken  out  1  predicted direction for pc_f (combinational)
- pred_ghr  out  GHR_WIDTH  GHR snapshot used for this prediction; carried down the pipeline
- pc_e  in  32  EX PC of the resolved branch
- cflow_valid  in  1  conditional branch resolved in EX
- cflow_taken  in  1  actual outcome
- cflow_ghr  in  GHR_WIDTH  pred_ghr snapshot that travelled with the branch
- mispredict  in  1  EX direction mispredict; restores the GHR
- init_done  out  1  table sweep complete

Behaviour:
- Index:
  - idx_f = pc_f[2 +: INDEX_WIDTH] ^ zero-extended ghr.
  - idx_e = pc_e[2 +: INDEX_WIDTH] ^ zero-extended cflow_ghr.
  - So update hits exactly the entry that predicted.
- Counter:
  - Unsigned, CTR_WIDTH bits. Prediction = counter MSB.
  - Init value WNT = 2^(CTR_WIDTH-1)-1.
  - Taken: +1, saturating at all-ones. Not taken: −1, saturating at 0. No wrap.
- FSM states INIT and RUN:
  - Reset (async): state=INIT, sweep ptr=0, ghr=0, init_done=0. Outputs bht_taken=0, pred_ghr=0.
  - INIT: write WNT to entry ptr each cycle; ptr++. After ptr==TABLE_ENTRIES-1 is written, go to RUN. That is TABLE_ENTRIES cycles, with init_done=1 from the following cycle.
  - During INIT: bht_taken=0, pred_ghr=0. pred_valid, cflow_valid and mispredict are ignored; the GHR is not modified.
  - RUN is terminal until rst_n falls. Reset mid-sweep restarts the sweep from 0.
- RUN, per clock:
  - pred_ghr = ghr (combinational).
  - mispredict: ghr <= {cflow_ghr[GHR_WIDTH-2:0], cflow_taken}. This has priority over pred_valid in the same cycle; the speculative shift is discarded.
  - Else pred_valid: ghr <= {ghr[GHR_WIDTH-2:0], bht_taken}.
  - For GHR_WIDTH=1, the shifted-in bit alone is used.
  - cflow_valid: counter[idx_e] updated one cycle later; mispredict without cflow_valid does not touch the table.
- Read/write collision: idx_f==idx_e in the same cycle returns the pre-update counter (no bypass). Single write port; update write latency is 1 cycle.

Optional Feature:
- Macro BPU_GSHARE_EN.
- Defined: XOR indexing and the GHR as above.
- Undefined: bimodal mode.
  - idx = PC bits only; GHR register not instantiated.
  - pred_ghr tied to 0; cflow_ghr and mispredict ignored.
  - Counter, init and saturation behaviour unchanged.

Decomposition:
- riscv_defines gains:
  - default constants BPU_TABLE_ENTRIES, BPU_CTR_WIDTH, BPU_GHR_WIDTH;
  - the bpu_state_t enum {INIT, RUN};
  - function ctr_wnt(width).
- Legacy bht_state_t remains for the old table.
- Sub-module sat_counter (combinational, parametrised CTR_WIDTH): inputs ctr, taken; output next ctr. One instance for the update path.

Test Plan:
- Reset, TABLE_ENTRIES=64, CTR_WIDTH=2 -> init_done rises after exactly 64 clocks. Every entry then predicts not-taken, with value 1 on backdoor read.
- Same pc_e=0x100, ghr=0; 3 taken updates -> counter goes 1→2→3→3 and bht_taken=1 after the first. Then 4 not-taken -> 2,1,0,0.
- CTR_WIDTH=3 -> init 3; needs 1 taken to flip to taken (4) and saturates at 7. From 7, 4 not-taken needed to predict not-taken.
- GSHARE_EN, pc_f=0x40, ghr=6'b000011 -> idx=0x10^0x03=0x13. Updating with cflow_ghr=3 touches entry 0x13 only; entry 0x10 unchanged.
- ghr=6'b101010, pred_valid=1, bht_taken=1, same cycle mispredict=1, cflow_ghr=6'b000111, cflow_taken=0 -> ghr=6'b001110 next cycle.
- Reset asserted at sweep ptr=20 and released -> sweep restarts from 0; init_done after 64 further cycles. cflow_valid pulses during INIT leave the table and GHR unchanged.
